// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_gen_pkg: default 640x480@60 timing constants and window decode helper
package vga_timing_gen_pkg;
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_CLK_DIV   = 2;
  localparam bit DEF_SYNC_POL  = 1'b0;

  function automatic logic in_win(int v, int lo, int len);
    return v >= lo && v < lo + len;
  endfunction
endpackage

// File: rtl/vga_timing_gen_tick_divider.sv
// tick_divider: one-clk strobe on the last of every DIV enabled clocks
module tick_divider #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  logic [DW-1:0] r_cnt;
  logic          w_last;
  assign w_last = r_cnt == DW'(DIV - 1);
  assign tick   = enable && !reset && w_last;
  // count 0..DIV-1, frozen while disabled
  always_ff @(posedge clk)
    if (reset) r_cnt <= '0;
    else if (enable) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel strobe, raster counters and registered sync/video decode
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter bit SYNC_POL  = DEF_SYNC_POL,
  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          p_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [HW-1:0] pixel_x,
  output logic [VW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start
);
  logic [HW-1:0] r_x, w_x_nxt;
  logic [VW-1:0] r_y, w_y_nxt;
  logic          r_hs, r_vs, r_vid;
  logic          w_tick, w_eol, w_eof;

  tick_divider #(.DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (w_tick)
  );

  assign w_eol = r_x == HW'(H_TOTAL - 1);
  assign w_eof = r_y == VW'(V_TOTAL - 1);

  // next raster position, wrapping at line and frame ends
  always_comb begin
    w_x_nxt = w_eol ? '0 : r_x + 1'b1;
    w_y_nxt = !w_eol ? r_y : w_eof ? '0 : r_y + 1'b1;
  end

  // advance on the pixel strobe; sync/video decoded from the next position so they line up with the counters
  always_ff @(posedge clk)
    if (reset) begin
      r_x   <= '0;
      r_y   <= '0;
      r_hs  <= ~SYNC_POL;
      r_vs  <= ~SYNC_POL;
      r_vid <= 1'b1;
    end else if (w_tick) begin
      r_x   <= w_x_nxt;
      r_y   <= w_y_nxt;
      r_hs  <= in_win(int'(w_x_nxt), H_DISPLAY + H_FRONT, H_SYNC) ? SYNC_POL : ~SYNC_POL;
      r_vs  <= in_win(int'(w_y_nxt), V_DISPLAY + V_FRONT, V_SYNC) ? SYNC_POL : ~SYNC_POL;
      r_vid <= in_win(int'(w_x_nxt), 0, H_DISPLAY) && in_win(int'(w_y_nxt), 0, V_DISPLAY);
    end

  assign p_tick      = w_tick;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign video_on    = r_vid;
  assign pixel_x     = r_x;
  assign pixel_y     = r_y;
  assign line_start  = w_tick && r_x == '0;
  assign frame_start = w_tick && r_x == '0 && r_y == '0;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench over default, fast/positive-sync and tiny-raster instances
module tb_vga_timing_gen;
  typedef struct packed {
    logic        tick, hs, vs, vid, ls, fs;
    logic [15:0] x, y;
  } out_t;

  logic clk = 1'b0, reset = 1'b1, enable = 1'b1;
  always #5 clk = ~clk;

  logic       t0, h0, v0, d0, l0, f0;
  logic [9:0] x0, y0;
  logic       t1, h1, v1, d1, l1, f1;
  logic [9:0] x1, y1;
  logic       t2, h2, v2, d2, l2, f2;
  logic [3:0] x2, y2;

  vga_timing_gen u_dut0 (
    .clk(clk), .reset(reset), .enable(enable), .p_tick(t0), .hsync(h0), .vsync(v0),
    .video_on(d0), .pixel_x(x0), .pixel_y(y0), .line_start(l0), .frame_start(f0)
  );

  vga_timing_gen #(.CLK_DIV(1), .SYNC_POL(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .p_tick(t1), .hsync(h1), .vsync(v1),
    .video_on(d1), .pixel_x(x1), .pixel_y(y1), .line_start(l1), .frame_start(f1)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .CLK_DIV(3), .SYNC_POL(1'b0)
  ) u_dut2 (
    .clk(clk), .reset(reset), .enable(enable), .p_tick(t2), .hsync(h2), .vsync(v2),
    .video_on(d2), .pixel_x(x2), .pixel_y(y2), .line_start(l2), .frame_start(f2)
  );

  int   n_chk = 0, n_fail = 0;
  int   n = 0;
  bit   valid = 0;
  out_t q0[$], q1[$], q2[$];
  int   tick_cnt = 0, clk_cnt = 0, last_tick = 0, last_clk = 0, extra = 0;
  int   last_fs = 0, extra2 = 0, rclk = 0;
  bit   have_act = 0, have_fs = 0, seen_tick = 0, prev_hs0 = 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // n = enabled, non-reset clocks since reset; everything else follows arithmetically
  function automatic out_t model(int k, bit act, int d, int hd, int hf, int hsw, int hb,
                                 int vd, int vf, int vsw, int vb, bit pol);
    out_t o;
    int ht, vt, p, x, y;
    ht = hd + hf + hsw + hb;
    vt = vd + vf + vsw + vb;
    p = (k / d) % (ht * vt);
    x = p % ht;
    y = p / ht;
    o.tick = act && (k % d == d - 1);
    o.x = 16'(x);
    o.y = 16'(y);
    o.hs = (x >= hd + hf && x < hd + hf + hsw) ? pol : ~pol;
    o.vs = (y >= vd + vf && y < vd + vf + vsw) ? pol : ~pol;
    o.vid = x < hd && y < vd;
    o.ls = o.tick && x == 0;
    o.fs = o.ls && y == 0;
    return o;
  endfunction

  function automatic out_t m0(int k, bit a);
    return model(k, a, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
  endfunction
  function automatic out_t m1(int k, bit a);
    return model(k, a, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1);
  endfunction
  function automatic out_t m2(int k, bit a);
    return model(k, a, 3, 8, 2, 3, 2, 6, 2, 2, 3, 1'b0);
  endfunction

  task automatic step(input bit rst, input bit en);
    out_t a;
    @(negedge clk);
    reset = rst;
    enable = en;
    if (valid) begin
      q0.push_back(m0(n, en && !rst));
      q1.push_back(m1(n, en && !rst));
      q2.push_back(m2(n, en && !rst));
    end
    #1;
    if (valid) begin
      a = {t0, h0, v0, d0, l0, f0, 16'(x0), 16'(y0)};
      chk("dut0", 64'(a), 64'(q0.pop_front()));
      a = {t1, h1, v1, d1, l1, f1, 16'(x1), 16'(y1)};
      chk("dut1", 64'(a), 64'(q1.pop_front()));
      a = {t2, h2, v2, d2, l2, f2, 16'(x2), 16'(y2)};
      chk("dut2", 64'(a), 64'(q2.pop_front()));
      if (!rst) begin
        if (!h0 && prev_hs0) begin
          chk("hs_start_x", 64'(x0), 64'(656));
          if (have_act) begin
            chk("h_ticks", 64'(tick_cnt - last_tick), 64'(800));
            chk("h_clks", 64'(clk_cnt - last_clk), 64'(1600 + extra));
            extra = 0;
          end
          have_act = 1;
          last_tick = tick_cnt;
          last_clk = clk_cnt;
        end
        if (h0 && !prev_hs0 && have_act) chk("hs_width", 64'(tick_cnt - last_tick), 64'(96));
        if (t0 && !seen_tick) begin
          chk("first_fs", 64'(f0), 64'(1));
          chk("first_tick_lat", 64'(clk_cnt - rclk), 64'(2));
          seen_tick = 1;
        end
        if (f2) begin
          if (have_fs) chk("frame_clks", 64'(clk_cnt - last_fs), 64'(585 + extra2));
          extra2 = 0;
          have_fs = 1;
          last_fs = clk_cnt;
        end
      end
    end
    if (rst) begin
      n = 0;
      valid = 1;
      have_act = 0;
      have_fs = 0;
      seen_tick = 0;
      extra = 0;
      extra2 = 0;
      rclk = clk_cnt;
    end else if (en) n++;
    prev_hs0 = h0;
    if (t0) tick_cnt++;
    clk_cnt++;
  endtask

  initial begin
    repeat (3) step(1'b1, 1'b1);
    repeat (4000) step(1'b0, 1'b1);
    while (m0(n, 1'b1).x != 16'd300) step(1'b0, 1'b1);
    extra = 37;
    extra2 = 37;
    repeat (37) step(1'b0, 1'b0);
    repeat (3400) step(1'b0, 1'b1);
    while (!(m0(n, 1'b1).x == 16'd500 && m0(n, 1'b1).y >= 16'd1)) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (2000) step(1'b0, 1'b1);
    chk("sb_empty", 64'(q0.size() + q1.size() + q2.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
